// File: rtl/secded_top_level.sv
// ---------------------------------------------------------------------------
// secded_top_level
//   SECDED (Hamming 16,11 plus overall parity) decoder with its own byte
//   data memory. Each run reads NUM_WORDS 16-bit codewords from the input
//   area, decodes them, and writes back {flags[1:0], 3'b000, data[10:0]}
//   words to the output area, one byte per cycle. It then raises done.
//
//   Ports
//     clk   in  1  single clock; all state changes on posedge
//     req   in  1  synchronous active-high reset; the first posedge with
//                  req low after reset starts a run
//     done  out 1  high once all results are written; held until next req
//
//   Control protocol: req is a level-sensitive run gate rather than a
//   valid/ready pair. While req is high the block sits in IDLE. Dropping req
//   launches exactly one run. done is a registered sticky flag that only req
//   clears. Raising req at any time aborts the current run.
//
//   The memory is instance dm1 with array core[] so its contents can be
//   preloaded and inspected hierarchically. Reset never clears it.
// ---------------------------------------------------------------------------

// Byte-wide memory: one combinational read port and one synchronous write port.
//   clk_i    in  1        write clock
//   we_i     in  1        write enable
//   waddr_i  in  AW       write byte address
//   wdata_i  in  8        write byte
//   raddr_i  in  AW       read byte address
//   rdata_o  out 8        read byte (combinational)
module secded_dmem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);
   logic [7:0] core [DEPTH];

   // Plain always (not always_ff): the array is also loaded from outside
   // the design, so it must not be claimed as single-process storage.
   always @(posedge clk_i) begin
      if (we_i) core[waddr_i] <= wdata_i;
   end

   assign rdata_o = core[raddr_i];
endmodule

module secded_top_level #(
   parameter int NUM_WORDS = 15,
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int MEM_DEPTH = 256
) (
   input  logic clk,
   input  logic req,
   output logic done
);
   localparam int AW    = $clog2(MEM_DEPTH);
   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [AW-1:0]    SRC_A    = AW'(SRC_BASE);
   localparam logic [AW-1:0]    DST_A    = AW'(DST_BASE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_LO = 3'd1,
      S_RD_HI = 3'd2,
      S_WR_LO = 3'd3,
      S_WR_HI = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [15:0]      word_q;
   logic             done_q;

   logic [AW-1:0] word_off;
   logic [AW-1:0] raddr, waddr;
   logic [7:0]    rdata, wdata;
   logic          we;

   // Decode datapath, all driven from the assembled codeword in word_q.
   logic [3:0]  syn;
   logic        par;
   logic [15:0] corr;
   logic [1:0]  flags;
   logic [10:0] data;
   logic [15:0] out_word;
   logic        unused_par_bits;

   // Byte offset of word idx within either area: 2*idx.
   assign word_off = AW'({idx_q, 1'b0});

   assign syn[3] = ^word_q[15:8];
   assign syn[2] = ^{word_q[15:12], word_q[7:4]};
   assign syn[1] = ^{word_q[15], word_q[14], word_q[11], word_q[10],
                     word_q[7],  word_q[6],  word_q[3],  word_q[2]};
   assign syn[0] = ^{word_q[15], word_q[13], word_q[11], word_q[9],
                     word_q[7],  word_q[5],  word_q[3],  word_q[1]};
   assign par    = ^word_q;

   // Odd overall parity means one flipped bit, located by the syndrome.
   // A zero syndrome then points at p0, which carries no data.
   assign corr  = par ? (word_q ^ (16'h0001 << syn)) : word_q;
   assign flags = par ? 2'b01 : ((syn != 4'd0) ? 2'b10 : 2'b00);
   assign data  = {corr[15:9], corr[7:5], corr[3]};
   assign out_word = {flags, 3'b000, data};

   // Parity positions are consumed by the syndrome, not by the output word.
   assign unused_par_bits = ^{corr[8], corr[4], corr[2:0]};

   always_comb begin
      raddr = SRC_A + word_off;
      waddr = DST_A + word_off;
      we    = 1'b0;
      wdata = out_word[7:0];
      unique case (state_q)
         S_RD_HI: raddr = SRC_A + word_off + AW'(1);
         S_WR_LO: we    = 1'b1;
         S_WR_HI: begin
            we    = 1'b1;
            waddr = DST_A + word_off + AW'(1);
            wdata = out_word[15:8];
         end
         default: ;
      endcase
   end

   secded_dmem #(.DEPTH(MEM_DEPTH), .AW(AW)) dm1 (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk) begin
      if (req) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE:  state_q <= S_RD_LO;
            S_RD_LO: begin
               word_q[7:0] <= rdata;
               state_q     <= S_RD_HI;
            end
            S_RD_HI: begin
               word_q[15:8] <= rdata;
               state_q      <= S_WR_LO;
            end
            S_WR_LO: state_q <= S_WR_HI;
            S_WR_HI: begin
               if (idx_q == LAST_IDX) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= S_RD_LO;
               end
            end
            S_DONE:  state_q <= S_DONE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign done = done_q;
endmodule

// File: tb/tb_secded_top_level.sv
module tb_secded_top_level;
   localparam int NW  = 15;
   localparam int SRC = 30;

   logic clk;
   logic req;
   logic done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   logic [7:0]  shadow [256];
   logic [15:0] in_words [NW];
   logic [15:0] dir_w [6];

   secded_top_level dut (
      .clk  (clk),
      .req  (req),
      .done (done)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] w;
      logic        p;
      w = '0;
      w[3]     = d[0];
      w[7:5]   = d[3:1];
      w[15:9]  = d[10:4];
      for (int pb = 1; pb <= 8; pb = pb * 2) begin
         p = 1'b0;
         for (int k = 1; k < 16; k++) if ((k & pb) != 0 && k != pb) p ^= w[k];
         w[pb] = p;
      end
      w[0] = ^w[15:1];
      return w;
   endfunction

   function automatic logic [15:0] ref_decode(input logic [15:0] cw);
      logic [15:0] w;
      int          s;
      int          p;
      logic [1:0]  f;
      w = cw;
      s = 0;
      p = 0;
      for (int k = 0; k < 16; k++) begin
         if (w[k]) begin
            p = p ^ 1;
            if (k != 0) s = s ^ k;
         end
      end
      if (p == 1) begin
         w[s] = ~w[s];
         f = 2'b01;
      end else if (s != 0) begin
         f = 2'b10;
      end else begin
         f = 2'b00;
      end
      return {f, 3'b000, w[15:9], w[7:5], w[3]};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [15:0] dut_out(input int i);
      return {dut.dm1.core[2*i+1], dut.dm1.core[2*i]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic fill_memory();
      logic [7:0] b;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom_range(0, 255));
         dut.dm1.core[i] = b;
         shadow[i] = b;
      end
   endtask

   task automatic load_word(input int i, input logic [15:0] w);
      dut.dm1.core[SRC + 2*i]     = w[7:0];
      dut.dm1.core[SRC + 2*i + 1] = w[15:8];
      shadow[SRC + 2*i]     = w[7:0];
      shadow[SRC + 2*i + 1] = w[15:8];
      in_words[i] = w;
   endtask

   task automatic push_expected();
      for (int i = 0; i < NW; i++) exp_q.push_back(ref_decode(in_words[i]));
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 80) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic score_outputs(input string tag);
      logic [15:0] e;
      int          bad;
      for (int i = 0; i < NW; i++) begin
         if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 16'd0, 16'd1);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s_word%0d", tag, i), dut_out(i), e);
         end
      end
      bad = 0;
      for (int a = 2*NW; a < 256; a++) if (dut.dm1.core[a] !== shadow[a]) bad++;
      check({tag, "_untouched_bytes"}, 16'(bad), 16'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          cyc;
      logic [15:0] w;
      int          nf;
      int          a;
      int          b;

      req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", {15'd0, done}, 16'd0);

      fill_memory();
      dir_w[0] = 16'h000F;
      dir_w[1] = 16'h002F;
      dir_w[2] = 16'h000E;
      dir_w[3] = 16'h022F;
      dir_w[4] = 16'hFFFF;
      dir_w[5] = 16'h7FFF;
      for (int i = 0; i < 6; i++) load_word(i, dir_w[i]);
      for (int i = 6; i < NW; i++) begin
         w  = encode(11'($urandom_range(0, 2047)));
         nf = i % 3;
         a  = $urandom_range(0, 15);
         b  = (a + $urandom_range(1, 15)) % 16;
         if (nf >= 1) w[a] = ~w[a];
         if (nf == 2) w[b] = ~w[b];
         load_word(i, w);
      end
      push_expected();

      // Run 1: full decode
      @(posedge clk); #1;
      req = 1'b0;
      wait_done(cyc);
      check("run1_done", {15'd0, done}, 16'd1);
      check("run1_within_70", {15'd0, (cyc <= 70)}, 16'd1);
      score_outputs("run1");
      check("clean_0001", dut_out(0), 16'h0001);
      check("bit5_flip", dut_out(1), 16'h4001);
      check("p0_flip", dut_out(2), 16'h4001);
      check("double_flag", {15'd0, dut.dm1.core[7][7]}, 16'd1);
      check("all_ones", dut_out(4), 16'h07FF);
      check("bit15_flip", dut_out(5), 16'h47FF);

      repeat (5) @(posedge clk);
      #1;
      check("done_held", {15'd0, done}, 16'd1);

      req = 1'b1;
      @(posedge clk); #1;
      check("done_cleared", {15'd0, done}, 16'd0);

      // Scramble the output area so the rerun has to rewrite every byte.
      for (int i = 0; i < 2*NW; i++) dut.dm1.core[i] = 8'($urandom_range(0, 255));
      push_expected();

      // Run 2: aborted at cycle 20, then restarted
      req = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      req = 1'b1;
      @(posedge clk); #1;
      check("abort_done_low", {15'd0, done}, 16'd0);
      @(posedge clk); #1;
      req = 1'b0;
      wait_done(cyc);
      check("run2_done", {15'd0, done}, 16'd1);
      check("run2_within_70", {15'd0, (cyc <= 70)}, 16'd1);
      score_outputs("run2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
